// File: rtl/anneal_scheduler.sv
// Iteration sequencer for the annealing neuron array: kicks the array, waits for network
// readiness, broadcasts one rotating-priority spike per iteration and decays the mu threshold.
module anneal_scheduler #(
    parameter int NUM_NEURON      = 128,
    parameter int NEURON_ID_WIDTH = 7,
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int FP_DATA_WIDTH   = 16,
    parameter int ITER_WIDTH      = 16,
    parameter int TIMEOUT         = 1023
) (
    input  logic                                      clk,
    input  logic                                      reset_l,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [ITER_WIDTH-1:0]                     num_iter,
    input  logic [NEURON_ID_WIDTH:0]                  active_neuron,
    input  logic [FP_DATA_WIDTH-1:0]                  mu_init,
    input  logic [ITER_WIDTH-1:0]                     mu_period,
    input  logic [NUM_NEURON-1:0]                     en_network_vec,
    input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]      spike_vec,
    output logic                                      en_neuron,
    output logic                                      en_spike,
    output logic                                      network_done,
    output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_bcast,
    output logic [FP_DATA_WIDTH-1:0]                  mu_out,
    output logic [ITER_WIDTH-1:0]                     iter_count,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam int IDX_W   = NEURON_ID_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE, KICK, WAIT_NET, BCAST, DONE, ERROR
    } state_t;

    state_t                                state_reg, state_next;
    logic [TIMER_W-1:0]                    timer_reg;
    logic                                  arm_reg;
    logic [NEURON_ID_WIDTH-1:0]            ptr_reg, ptr_next;
    logic [ITER_WIDTH-1:0]                 mu_cnt_reg;
    logic                                  en_neuron_reg, en_spike_reg, network_done_reg;
    logic                                  busy_reg, done_reg, err_reg;
    logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_bcast_reg, sel_bcast;
    logic [FP_DATA_WIDTH-1:0]              mu_reg;
    logic [ITER_WIDTH-1:0]                 iter_count_reg, iter_inc;

    logic [NUM_NEURON-1:0]                 active_mask, fire_vec, hi_vec;
    logic [TEN_DATA_WIDTH-1:0]             code_arr [NUM_NEURON];
    logic [NEURON_ID_WIDTH-1:0]            hi_idx, lo_idx, sel_idx;
    logic                                  hi_found, lo_found, sel_hit;
    logic [IDX_W-1:0]                      ptr_adv;
    logic                                  ready, accept, bad_active, launch, bcast_commit;

    // Per-neuron qualification: inside the active window, firing, and at/after the pointer.
    generate
        for (genvar gi = 0; gi < NUM_NEURON; gi++) begin : g_neuron
            localparam logic [IDX_W-1:0] IDX = IDX_W'(gi);
            assign code_arr[gi]    = spike_vec[gi*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
            assign active_mask[gi] = IDX < active_neuron;
            assign fire_vec[gi]    = active_mask[gi] &&
                                     (code_arr[gi] == TEN_DATA_WIDTH'(1) ||
                                      code_arr[gi] == TEN_DATA_WIDTH'(2));
            assign hi_vec[gi]      = fire_vec[gi] && (IDX >= {1'b0, ptr_reg});
        end
    endgenerate

    assign ready      = &(en_network_vec | ~active_mask);
    assign accept     = (state_reg == WAIT_NET) && ready && arm_reg;
    assign bad_active = (active_neuron == '0) || (active_neuron > IDX_W'(NUM_NEURON));
    assign launch     = (state_reg == IDLE || state_reg == ERROR) && start && !abort;
    assign bcast_commit = (state_reg == BCAST) && !abort;
    assign iter_inc   = iter_count_reg + ITER_WIDTH'(1);

    // Rotating priority: lowest firing index at/after ptr, else lowest firing index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_NEURON - 1; k >= 0; k--) begin
            if (hi_vec[k]) begin
                hi_found = 1'b1;
                hi_idx   = NEURON_ID_WIDTH'(k);
            end
            if (fire_vec[k]) begin
                lo_found = 1'b1;
                lo_idx   = NEURON_ID_WIDTH'(k);
            end
        end
    end

    always_comb begin
        sel_hit = hi_found | lo_found;
        sel_idx = hi_found ? hi_idx : lo_idx;
        if (sel_hit) begin
            sel_bcast = {code_arr[sel_idx], sel_idx};
            ptr_adv   = {1'b0, sel_idx} + IDX_W'(1);
        end else begin
            sel_bcast = {{TEN_DATA_WIDTH{1'b0}}, ptr_reg};
            ptr_adv   = {1'b0, ptr_reg} + IDX_W'(1);
        end
        ptr_next = (ptr_adv >= active_neuron) ? '0 : ptr_adv[NEURON_ID_WIDTH-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, ERROR: begin
                if (start) begin
                    if (bad_active)          state_next = ERROR;
                    else if (num_iter == '0) state_next = DONE;
                    else                     state_next = KICK;
                end
            end
            KICK:     state_next = WAIT_NET;
            WAIT_NET: begin
                if (accept)                                  state_next = BCAST;
                else if (timer_reg == TIMER_W'(TIMEOUT - 1)) state_next = ERROR;
            end
            BCAST:    state_next = (iter_inc == num_iter) ? DONE : WAIT_NET;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // fp16 halving: exponent decrement, underflow to signed zero, inf/NaN untouched.
    function automatic logic [15:0] mu_halve(input logic [15:0] m);
        logic [4:0] e;
        e = m[14:10];
        if (e == 5'd31)     return m;
        else if (e <= 5'd1) return {m[15], 15'd0};
        else                return {m[15], e - 5'd1, m[9:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_reg        <= IDLE;
            timer_reg        <= '0;
            arm_reg          <= 1'b0;
            ptr_reg          <= '0;
            mu_cnt_reg       <= '0;
            en_neuron_reg    <= 1'b0;
            en_spike_reg     <= 1'b0;
            network_done_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            spike_bcast_reg  <= '0;
            mu_reg           <= '0;
            iter_count_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            en_neuron_reg    <= !(state_next == IDLE || state_next == ERROR);
            en_spike_reg     <= (state_next == KICK);
            network_done_reg <= (state_next == BCAST);
            done_reg         <= (state_next == DONE);
            busy_reg         <= (state_next == KICK || state_next == WAIT_NET ||
                                 state_next == BCAST);
            timer_reg        <= (state_reg == WAIT_NET) ? timer_reg + TIMER_W'(1) : '0;

            // A fresh rising edge of ready is needed after every broadcast.
            if (state_reg == KICK)                         arm_reg <= 1'b1;
            else if (state_reg == BCAST)                   arm_reg <= 1'b0;
            else if (state_reg == WAIT_NET && !ready)      arm_reg <= 1'b1;

            if (launch) begin
                err_reg <= bad_active;
                if (state_next == KICK) begin
                    mu_reg         <= mu_init;
                    iter_count_reg <= '0;
                    ptr_reg        <= '0;
                    mu_cnt_reg     <= '0;
                end
            end else if (state_next == ERROR) begin
                err_reg <= 1'b1;
            end

            if (accept && !abort) begin
                spike_bcast_reg <= sel_bcast;
                ptr_reg         <= ptr_next;
            end

            if (bcast_commit) begin
                iter_count_reg <= iter_inc;
                if (mu_period != '0) begin
                    if (mu_cnt_reg + ITER_WIDTH'(1) == mu_period) begin
                        mu_reg     <= mu_halve(mu_reg);
                        mu_cnt_reg <= '0;
                    end else begin
                        mu_cnt_reg <= mu_cnt_reg + ITER_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign en_neuron    = en_neuron_reg;
    assign en_spike     = en_spike_reg;
    assign network_done = network_done_reg;
    assign spike_bcast  = spike_bcast_reg;
    assign mu_out       = mu_reg;
    assign iter_count   = iter_count_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_anneal_scheduler.sv
// Directed bench for anneal_scheduler: rotating selection, mu decay, timeout, abort and edge cases.
module tb_anneal_scheduler;

    logic         clk = 1'b0;
    logic         reset_l, start, abort;
    logic [15:0]  num_iter, mu_init, mu_period;
    logic [7:0]   active_neuron;
    logic [127:0] en_network_vec;
    logic [255:0] spike_vec;
    logic         en_neuron, en_spike, network_done, busy, done, err;
    logic [8:0]   spike_bcast;
    logic [15:0]  mu_out, iter_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int seen;

    always #5 clk = ~clk;

    anneal_scheduler dut (
        .clk(clk), .reset_l(reset_l), .start(start), .abort(abort),
        .num_iter(num_iter), .active_neuron(active_neuron), .mu_init(mu_init),
        .mu_period(mu_period), .en_network_vec(en_network_vec), .spike_vec(spike_vec),
        .en_neuron(en_neuron), .en_spike(en_spike), .network_done(network_done),
        .spike_bcast(spike_bcast), .mu_out(mu_out), .iter_count(iter_count),
        .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise readiness after a fixed delay, expect the strobe one cycle later, step past BCAST.
    task automatic do_iter(input logic [127:0] net, input logic [8:0] exp_bcast,
                           input bit drop, input string tag);
        repeat (2) @(negedge clk);
        en_network_vec = net;
        @(negedge clk);
        check({tag, " strobe"}, network_done, 1);
        check({tag, " bcast"}, spike_bcast, exp_bcast);
        $display("iter %s: bcast=%03h mu=%04h", tag, spike_bcast, mu_out);
        if (drop) en_network_vec = '0;
        @(negedge clk);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [15:0] mu_exp [6];

    initial begin
        reset_l = 1'b0; start = 1'b0; abort = 1'b0;
        num_iter = '0; mu_init = '0; mu_period = '0; active_neuron = '0;
        en_network_vec = '0; spike_vec = '0;
        repeat (2) @(negedge clk);
        check("reset en_neuron", en_neuron, 0);
        check("reset busy", busy, 0);
        check("reset err", err, 0);
        check("reset bcast", spike_bcast, 0);
        check("reset mu", mu_out, 0);
        reset_l = 1'b1;
        @(negedge clk);

        // Rotating selection over codes {0,1,2,0}
        active_neuron = 8'd4; num_iter = 16'd3; mu_init = 16'h3C00; mu_period = '0;
        spike_vec = '0; spike_vec[3:2] = 2'd1; spike_vec[5:4] = 2'd2;
        start_run();
        check("kick en_spike", en_spike, 1);
        check("kick busy", busy, 1);
        @(negedge clk);
        check("kick one cycle", en_spike, 0);
        do_iter('1, 9'h081, 1, "t1.1");
        do_iter('1, 9'h102, 1, "t1.2");
        do_iter('1, 9'h081, 1, "t1.3");
        check("t1 done", done, 1);
        check("t1 iter_count", iter_count, 3);
        check("t1 busy low", busy, 0);
        @(negedge clk);
        check("t1 done pulse", done, 0);
        check("t1 idle en_neuron", en_neuron, 0);

        // No firing: pointer walks and wraps; also ready must fall before re-arming
        active_neuron = 8'd3; num_iter = 16'd4; spike_vec = '0;
        start_run();
        do_iter('1, 9'h000, 0, "t2.1");
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (network_done) seen++;
        end
        check("t2 no re-strobe while ready held", seen, 0);
        en_network_vec = '0;
        do_iter('1, 9'h001, 1, "t2.2");
        do_iter('1, 9'h002, 1, "t2.3");
        do_iter('1, 9'h000, 1, "t2.4");
        check("t2 done", done, 1);
        @(negedge clk);

        // mu decay every 2 iterations
        mu_exp[0] = 16'h4800; mu_exp[1] = 16'h4400; mu_exp[2] = 16'h4400;
        mu_exp[3] = 16'h4000; mu_exp[4] = 16'h4000; mu_exp[5] = 16'h3C00;
        active_neuron = 8'd2; num_iter = 16'd6; mu_init = 16'h4800; mu_period = 16'd2;
        start_run();
        for (int i = 0; i < 6; i++) begin
            do_iter('1, (i % 2 == 0) ? 9'h000 : 9'h001, 1, $sformatf("t3.%0d", i + 1));
            check($sformatf("t3 mu after %0d", i + 1), mu_out, mu_exp[i]);
            check($sformatf("t3 iter after %0d", i + 1), iter_count, i + 1);
        end
        check("t3 done", done, 1);
        @(negedge clk);

        // Underflow to zero and infinity held
        num_iter = 16'd1; mu_init = 16'h0400; mu_period = 16'd1;
        start_run();
        do_iter('1, 9'h000, 1, "t3b");
        check("t3b mu underflow", mu_out, 16'h0000);
        @(negedge clk);
        mu_init = 16'h7C00;
        start_run();
        do_iter('1, 9'h000, 1, "t3c");
        check("t3c mu inf held", mu_out, 16'h7C00);
        @(negedge clk);

        // Timeout with neuron 2 never ready
        active_neuron = 8'd4; num_iter = 16'd2; mu_period = '0;
        en_network_vec = '1; en_network_vec[2] = 1'b0;
        start_run();
        repeat (1023) @(negedge clk);
        check("timeout not early err", err, 0);
        check("timeout not early en_neuron", en_neuron, 1);
        @(negedge clk);
        check("timeout err", err, 1);
        check("timeout en_neuron", en_neuron, 0);
        check("timeout busy", busy, 0);
        en_network_vec = '0;

        // Start from ERROR with num_iter 0: err cleared, immediate done, no kick
        num_iter = 16'd0;
        start_run();
        check("zero-iter done", done, 1);
        check("zero-iter no en_spike", en_spike, 0);
        check("start clears err", err, 0);
        @(negedge clk);
        check("zero-iter done pulse", done, 0);

        // active_neuron 0 -> error; abort leaves err held
        active_neuron = 8'd0; num_iter = 16'd3;
        start_run();
        check("bad active err", err, 1);
        check("bad active en_neuron", en_neuron, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort from error holds err", err, 1);

        // Abort in WAIT_NET while ready rises
        active_neuron = 8'd4; num_iter = 16'd5;
        start_run();
        check("restart clears err", err, 0);
        @(negedge clk);
        abort = 1'b1; en_network_vec = '1;
        @(negedge clk);
        abort = 1'b0;
        check("abort no network_done", network_done, 0);
        check("abort busy low", busy, 0);
        @(negedge clk);
        check("abort stays idle", network_done, 0);
        en_network_vec = '0;

        // abort and start together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort beats start", en_spike, 0);
        check("abort beats start busy", busy, 0);

        // Bits above active_neuron ignored for ready and selection
        active_neuron = 8'd2; num_iter = 16'd2;
        spike_vec = '0; spike_vec[11:10] = 2'd1;
        start_run();
        do_iter(128'h3, 9'h000, 1, "t6.1");
        do_iter(128'h3, 9'h001, 1, "t6.2");
        check("t6 done", done, 1);
        @(negedge clk);

        // Reset mid-run
        num_iter = 16'd5; mu_init = 16'h3C00;
        start_run();
        @(negedge clk);
        reset_l = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        check("midrun reset busy", busy, 0);
        check("midrun reset mu", mu_out, 0);
        check("midrun reset en_neuron", en_neuron, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
